parity_check_seq: RTL and testbench

//  Sequential, parametrised parity checker for the UART RX path. It XOR-accumulates

---
 rtl/parity_check_seq.sv | 125 ++++++++++++
 tb/tb_parity_check_seq.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/parity_check_seq.sv
// Sequential UART RX parity checker: XOR-accumulates strobed data bits and checks the
// received parity bit against even/odd/mark/space. Also keeps a sticky flag and a saturating error count.
module parity_check_seq #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 frame_start,
  input  logic                 par_chk_en,
  input  logic [1:0]           par_mode,
  input  logic                 smpl_ready,
  input  logic                 sampled_bit,
  input  logic                 err_clr,
  output logic                 busy,
  output logic                 par_done,
  output logic                 par_err,
  output logic                 par_err_sticky,
  output logic [CNT_WIDTH-1:0] err_cnt
);

  localparam int unsigned BCW = $clog2(DATA_WIDTH + 1);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY} state_t;
  typedef enum logic [1:0] {EVEN = 2'b00, ODD = 2'b01, MARK = 2'b10, SPACE = 2'b11} mode_t;

  state_t               state, state_d;
  mode_t                mode_q, mode_d;
  logic                 en_q, en_d;
  logic                 acc, acc_d;
  logic [BCW-1:0]       bit_cnt, bit_cnt_d;
  logic                 done_d, perr_d, sticky_d;
  logic [CNT_WIDTH-1:0] cnt_d;
  logic                 exp_par, err_ev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      mode_q         <= EVEN;
      en_q           <= 1'b0;
      acc            <= 1'b0;
      bit_cnt        <= '0;
      par_done       <= 1'b0;
      par_err        <= 1'b0;
      par_err_sticky <= 1'b0;
      err_cnt        <= '0;
    end else begin
      state          <= state_d;
      mode_q         <= mode_d;
      en_q           <= en_d;
      acc            <= acc_d;
      bit_cnt        <= bit_cnt_d;
      par_done       <= done_d;
      par_err        <= perr_d;
      par_err_sticky <= sticky_d;
      err_cnt        <= cnt_d;
    end
  end

  always_comb begin
    unique case (mode_q)
      EVEN:    exp_par = acc;
      ODD:     exp_par = ~acc;
      MARK:    exp_par = 1'b1;
      default: exp_par = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state;
    mode_d    = mode_q;
    en_d      = en_q;
    acc_d     = acc;
    bit_cnt_d = bit_cnt;
    done_d    = 1'b0;
    perr_d    = 1'b0;
    err_ev    = 1'b0;
    sticky_d  = par_err_sticky;
    cnt_d     = err_cnt;

    // frame_start restarts from any state and swallows a coincident strobe
    if (frame_start) begin
      state_d   = DATA;
      en_d      = par_chk_en;
      mode_d    = mode_t'(par_mode);
      acc_d     = 1'b0;
      bit_cnt_d = '0;
    end else begin
      unique case (state)
        DATA: if (smpl_ready) begin
          acc_d     = acc ^ sampled_bit;
          bit_cnt_d = bit_cnt + BCW'(1);
          if (bit_cnt == LAST_BIT) begin
            if (en_q) begin
              state_d = PARITY;
            end else begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end
        end
        PARITY: if (smpl_ready) begin
          err_ev  = sampled_bit ^ exp_par;
          done_d  = 1'b1;
          perr_d  = err_ev;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    if (err_ev) begin
      sticky_d = 1'b1;
      if (err_clr)             cnt_d = CNT_WIDTH'(1);
      else if (err_cnt != '1)  cnt_d = err_cnt + CNT_WIDTH'(1);
    end else if (err_clr) begin
      sticky_d = 1'b0;
      cnt_d    = '0;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_parity_check_seq.sv
// Directed bench for parity_check_seq (DATA_WIDTH=8, CNT_WIDTH=2 so saturation is reachable).
module tb_parity_check_seq;

  logic       clk, rst;
  logic       frame_start, par_chk_en, smpl_ready, sampled_bit, err_clr;
  logic [1:0] par_mode;
  logic       busy, par_done, par_err, par_err_sticky;
  logic [1:0] err_cnt;

  int total = 0;
  int bad   = 0;
  int done_seen = 0;

  parity_check_seq #(.DATA_WIDTH(8), .CNT_WIDTH(2)) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .par_chk_en(par_chk_en),
    .par_mode(par_mode), .smpl_ready(smpl_ready), .sampled_bit(sampled_bit),
    .err_clr(err_clr), .busy(busy), .par_done(par_done), .par_err(par_err),
    .par_err_sticky(par_err_sticky), .err_cnt(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (par_done === 1'b1) done_seen++;

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic start_frame(input logic en, input logic [1:0] mode);
    frame_start = 1'b1; par_chk_en = en; par_mode = mode;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    smpl_ready = 1'b1; sampled_bit = b;
    tick();
    smpl_ready = 1'b0; sampled_bit = 1'b0;
  endtask

  task automatic send_frame(input logic en, input logic [1:0] mode, input logic [7:0] data,
                            input logic pbit, input logic clr_on_par);
    start_frame(en, mode);
    for (int i = 0; i < 8; i++) send_bit(data[i]);
    if (en) begin
      err_clr = clr_on_par;
      send_bit(pbit);
      err_clr = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick(); tick();
    total++;
    if ({busy, par_done, par_err, par_err_sticky, err_cnt} !== 6'b0) begin
      bad++; $display("FAIL reset_outputs got=%b exp=000000", {busy, par_done, par_err, par_err_sticky, err_cnt});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_even_ok;
    send_frame(1'b1, 2'b00, 8'hA5, 1'b0, 1'b0);
    total++;
    if ({par_done, par_err, err_cnt} !== 4'b1000) begin
      bad++; $display("FAIL even_a5_ok got=%b exp=1000", {par_done, par_err, err_cnt});
    end
    tick();
    total++;
    if ({par_done, busy} !== 2'b00) begin
      bad++; $display("FAIL done_one_cycle got=%b exp=00", {par_done, busy});
    end
  endtask

  task automatic test_errors;
    send_frame(1'b1, 2'b00, 8'hA5, 1'b1, 1'b0);
    total++;
    if ({par_done, par_err, par_err_sticky, err_cnt} !== 5'b11101) begin
      bad++; $display("FAIL even_a5_err got=%b exp=11101", {par_done, par_err, par_err_sticky, err_cnt});
    end
    tick();
    total++;
    if ({par_err, par_err_sticky} !== 2'b01) begin
      bad++; $display("FAIL err_pulse_sticky got=%b exp=01", {par_err, par_err_sticky});
    end
    send_frame(1'b1, 2'b01, 8'h01, 1'b0, 1'b0);
    total++;
    if ({par_done, par_err, err_cnt} !== 4'b1001) begin
      bad++; $display("FAIL odd_01_ok got=%b exp=1001", {par_done, par_err, err_cnt});
    end
  endtask

  task automatic test_mark_space_noparity;
    send_frame(1'b1, 2'b10, 8'h00, 1'b0, 1'b0);
    total++;
    if ({par_done, par_err, err_cnt} !== 4'b1110) begin
      bad++; $display("FAIL mark_err got=%b exp=1110", {par_done, par_err, err_cnt});
    end
    send_frame(1'b1, 2'b11, 8'hFF, 1'b0, 1'b0);
    total++;
    if ({par_done, par_err, err_cnt} !== 4'b1010) begin
      bad++; $display("FAIL space_ok got=%b exp=1010", {par_done, par_err, err_cnt});
    end
    send_frame(1'b0, 2'b00, 8'hFF, 1'b0, 1'b0);
    total++;
    if ({par_done, par_err, busy} !== 3'b100) begin
      bad++; $display("FAIL no_parity_done got=%b exp=100", {par_done, par_err, busy});
    end
  endtask

  task automatic test_abort;
    int base;
    tick();
    base = done_seen;
    start_frame(1'b1, 2'b00);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    // restart with a coincident strobe that must be dropped
    smpl_ready = 1'b1; sampled_bit = 1'b1;
    frame_start = 1'b1; par_chk_en = 1'b1; par_mode = 2'b00;
    tick();
    frame_start = 1'b0; smpl_ready = 1'b0; sampled_bit = 1'b0;
    for (int i = 0; i < 8; i++) send_bit(i < 2);
    total++;
    if ({busy, par_done} !== 2'b10) begin
      bad++; $display("FAIL abort_awaits_parity got=%b exp=10", {busy, par_done});
    end
    send_bit(1'b0);
    total++;
    if ({par_done, par_err} !== 2'b10) begin
      bad++; $display("FAIL abort_frame_ok got=%b exp=10", {par_done, par_err});
    end
    tick();
    total++;
    if (done_seen - base !== 1) begin
      bad++; $display("FAIL abort_done_count got=%0d exp=1", done_seen - base);
    end
  endtask

  task automatic test_idle_and_latch;
    int base;
    base = done_seen;
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    total++;
    if ({busy, par_done, done_seen - base} !== {2'b00, 32'd0}) begin
      bad++; $display("FAIL idle_strobe_ignored got=%b/%0d exp=00/0", {busy, par_done}, done_seen - base);
    end
    start_frame(1'b1, 2'b00);
    par_mode = 2'b01; par_chk_en = 1'b0;
    for (int i = 0; i < 8; i++) send_bit(i[0] ? 1'b0 : 1'b1);
    send_bit(1'b0);
    total++;
    if ({par_done, par_err} !== 2'b10) begin
      bad++; $display("FAIL latched_mode got=%b exp=10", {par_done, par_err});
    end
  endtask

  task automatic test_saturate;
    logic [1:0] exp_cnt;
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    total++;
    if ({par_err_sticky, err_cnt} !== 3'b000) begin
      bad++; $display("FAIL clr_alone got=%b exp=000", {par_err_sticky, err_cnt});
    end
    for (int i = 0; i < 5; i++) begin
      send_frame(1'b1, 2'b00, 8'hA5, 1'b1, 1'b0);
      exp_cnt = (i >= 2) ? 2'd3 : 2'(i + 1);
      total++;
      if ({par_err_sticky, err_cnt} !== {1'b1, exp_cnt}) begin
        bad++; $display("FAIL sat_frame%0d got=%b exp=%b", i, {par_err_sticky, err_cnt}, {1'b1, exp_cnt});
      end
    end
    send_frame(1'b1, 2'b00, 8'hA5, 1'b1, 1'b1);
    total++;
    if ({par_err, par_err_sticky, err_cnt} !== 4'b1101) begin
      bad++; $display("FAIL clr_vs_err got=%b exp=1101", {par_err, par_err_sticky, err_cnt});
    end
  endtask

  task automatic test_reset_mid;
    int base;
    start_frame(1'b1, 2'b00);
    for (int i = 0; i < 6; i++) send_bit(1'b1);
    total++;
    if ({busy, par_err_sticky} !== 2'b11) begin
      bad++; $display("FAIL pre_reset_busy got=%b exp=11", {busy, par_err_sticky});
    end
    base = done_seen;
    rst = 1'b1;
    #1;
    total++;
    if ({busy, par_done, par_err, par_err_sticky, err_cnt} !== 6'b0) begin
      bad++; $display("FAIL async_reset got=%b exp=000000", {busy, par_done, par_err, par_err_sticky, err_cnt});
    end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    tick();
    total++;
    if ({busy, par_done, par_err, par_err_sticky, err_cnt, done_seen - base} !== {6'b0, 32'd0}) begin
      bad++; $display("FAIL post_reset_idle got=%b/%0d exp=000000/0",
                      {busy, par_done, par_err, par_err_sticky, err_cnt}, done_seen - base);
    end
  endtask

  initial begin
    frame_start = 1'b0; par_chk_en = 1'b0; par_mode = 2'b00;
    smpl_ready = 1'b0; sampled_bit = 1'b0; err_clr = 1'b0;
    test_reset();
    test_even_ok();
    test_errors();
    test_mark_space_noparity();
    test_abort();
    test_idle_and_latch();
    test_saturate();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
